// File: rtl/cycle_num_axil_pkg.sv
// Shared definitions for the cycle_num AXI4-Lite register slave: register map,
// response codes, FSM state types and the byte-strobe merge helper.
package cycle_num_axil_pkg;

  localparam logic [4:0] ADDR_SLV_REG0  = 5'h00;
  localparam logic [4:0] ADDR_SLV_REG1  = 5'h04;
  localparam logic [4:0] ADDR_SLV_REG2  = 5'h08;
  localparam logic [4:0] ADDR_SLV_REG3  = 5'h0C;
  localparam logic [4:0] ADDR_CYCLE_CNT = 5'h10;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } axi_resp_e;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_e;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] merged;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/cycle_num_counter.sv
// Free-running 32-bit cycle counter; clear has priority over enable and the
// count wraps naturally at 0xFFFFFFFF.
module cycle_num_counter (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic        i_clr,
  output logic [31:0] o_count
);

  logic [31:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= 32'd0;
    end else if (i_clr) begin
      r_count <= 32'd0;
    end else if (i_en) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/cycle_num_axil_slave.sv
// AXI4-Lite slave with four 32-bit registers; define CYCLE_NUM_CNT_EN to add a
// read-only cycle counter at 0x10 controlled by slv_reg0[0] (run) and [1] (clear).
// Handshake: a transfer occurs on a rising edge where VALID and READY are both 1;
// VALID/payload are held by this block until READY, and READY never waits on VALID.
module cycle_num_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg0,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg1,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg2,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg3
);
  import cycle_num_axil_pkg::*;

  logic             r_ready_en;
  w_state_e         r_wstate, w_wstate_next;
  r_state_e         r_rstate, w_rstate_next;
  logic             r_aw_done, r_w_done;
  logic [4:0]       r_awaddr;
  logic [31:0]      r_wdata;
  logic [3:0]       r_wstrb;
  axi_resp_e        r_bresp, r_rresp;
  logic [31:0]      r_rdata;
  logic [3:0][31:0] r_slv_reg;

  logic        w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_wr_mapped;
  logic [4:0]  w_waddr, w_raddr;
  logic [1:0]  w_wr_idx;
  logic [31:0] w_wdata_sel, w_wr_val, w_rd_data, w_count;
  logic [3:0]  w_wstrb_sel;
  axi_resp_e   w_wr_resp, w_rd_resp;
  logic        w_cnt_clr;
  logic        w_unused;

  // r_ready_en holds every READY low until the first edge after reset is released.
  assign s00_axi_awready = r_ready_en && (r_wstate == W_IDLE) && !r_aw_done;
  assign s00_axi_wready  = r_ready_en && (r_wstate == W_IDLE) && !r_w_done;
  assign s00_axi_arready = r_ready_en && (r_rstate == R_IDLE);
  assign s00_axi_bvalid  = (r_wstate == W_RESP);
  assign s00_axi_rvalid  = (r_rstate == R_DATA);
  assign s00_axi_bresp   = r_bresp;
  assign s00_axi_rresp   = r_rresp;
  assign s00_axi_rdata   = r_rdata;
  assign slv_reg0 = r_slv_reg[0];
  assign slv_reg1 = r_slv_reg[1];
  assign slv_reg2 = r_slv_reg[2];
  assign slv_reg3 = r_slv_reg[3];

  assign w_aw_hs = s00_axi_awvalid && s00_axi_awready;
  assign w_w_hs  = s00_axi_wvalid && s00_axi_wready;
  assign w_ar_hs = s00_axi_arvalid && s00_axi_arready;

  // A channel handshaking this cycle is used directly so the write lands without an extra cycle.
  assign w_waddr     = w_aw_hs ? s00_axi_awaddr[4:0] : r_awaddr;
  assign w_wdata_sel = w_w_hs ? s00_axi_wdata : r_wdata;
  assign w_wstrb_sel = w_w_hs ? s00_axi_wstrb : r_wstrb;
  assign w_commit    = (r_wstate == W_IDLE) && (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);
  assign w_wr_mapped = (w_waddr[4] == 1'b0);
  assign w_wr_idx    = w_waddr[3:2];
  assign w_wr_resp   = w_wr_mapped ? RESP_OKAY : RESP_SLVERR;
  assign w_raddr     = s00_axi_araddr[4:0];
  assign w_unused    = &{1'b0, s00_axi_awprot, s00_axi_arprot,
                         s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

`ifdef CYCLE_NUM_CNT_EN
  assign w_cnt_clr = w_commit && w_wr_mapped && (w_wr_idx == 2'd0) &&
                     w_wstrb_sel[0] && w_wdata_sel[1];

  cycle_num_counter u_counter (
    .i_clk   (s00_axi_aclk),
    .i_rst   (s00_axi_areset),
    .i_en    (r_slv_reg[0][0]),
    .i_clr   (w_cnt_clr),
    .o_count (w_count)
  );
`else
  assign w_cnt_clr = 1'b0;
  assign w_count   = 32'd0;
`endif

  always_comb begin
    w_wr_val = apply_wstrb(r_slv_reg[w_wr_idx], w_wdata_sel, w_wstrb_sel);
`ifdef CYCLE_NUM_CNT_EN
    if (w_wr_idx == 2'd0) w_wr_val[1] = 1'b0;
`endif
  end

  always_comb begin
    w_rd_data = 32'd0;
    w_rd_resp = RESP_SLVERR;
    if (w_raddr[4] == 1'b0) begin
      w_rd_data = r_slv_reg[w_raddr[3:2]];
      w_rd_resp = RESP_OKAY;
    end
`ifdef CYCLE_NUM_CNT_EN
    else if (w_raddr[4:2] == ADDR_CYCLE_CNT[4:2]) begin
      w_rd_data = w_count;
      w_rd_resp = RESP_OKAY;
    end
`endif
  end

  always_comb begin
    w_wstate_next = r_wstate;
    unique case (r_wstate)
      W_IDLE:  if (w_commit) w_wstate_next = W_RESP;
      W_RESP:  if (s00_axi_bready) w_wstate_next = W_IDLE;
      default: w_wstate_next = W_IDLE;
    endcase
  end

  always_comb begin
    w_rstate_next = r_rstate;
    unique case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_next = R_DATA;
      R_DATA:  if (s00_axi_rready) w_rstate_next = R_IDLE;
      default: w_rstate_next = R_IDLE;
    endcase
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      r_ready_en <= 1'b0;
      r_wstate   <= W_IDLE;
      r_rstate   <= R_IDLE;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_awaddr   <= 5'd0;
      r_wdata    <= 32'd0;
      r_wstrb    <= 4'd0;
      r_bresp    <= RESP_OKAY;
      r_rresp    <= RESP_OKAY;
      r_rdata    <= 32'd0;
      r_slv_reg  <= '0;
    end else begin
      r_ready_en <= 1'b1;
      r_wstate   <= w_wstate_next;
      r_rstate   <= w_rstate_next;
      if (w_commit) begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
        r_bresp   <= w_wr_resp;
        if (w_wr_mapped) r_slv_reg[w_wr_idx] <= w_wr_val;
      end else begin
        if (w_aw_hs) begin
          r_aw_done <= 1'b1;
          r_awaddr  <= s00_axi_awaddr[4:0];
        end
        if (w_w_hs) begin
          r_w_done <= 1'b1;
          r_wdata  <= s00_axi_wdata;
          r_wstrb  <= s00_axi_wstrb;
        end
      end
      if (w_ar_hs) begin
        r_rdata <= w_rd_data;
        r_rresp <= w_rd_resp;
      end
    end
  end

endmodule

// File: tb/tb_cycle_num_axil_slave.sv
// Directed self-checking bench for cycle_num_axil_slave; counter checks are
// compiled in when CYCLE_NUM_CNT_EN is defined.
module tb_cycle_num_axil_slave;

  logic        clk = 1'b0;
  logic        areset;
  logic [4:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [31:0] slv_reg0, slv_reg1, slv_reg2, slv_reg3;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_reg [4];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  cycle_num_axil_slave dut (
    .s00_axi_aclk    (clk),
    .s00_axi_areset  (areset),
    .s00_axi_awaddr  (awaddr),
    .s00_axi_awprot  (awprot),
    .s00_axi_awvalid (awvalid),
    .s00_axi_awready (awready),
    .s00_axi_wdata   (wdata),
    .s00_axi_wstrb   (wstrb),
    .s00_axi_wvalid  (wvalid),
    .s00_axi_wready  (wready),
    .s00_axi_bresp   (bresp),
    .s00_axi_bvalid  (bvalid),
    .s00_axi_bready  (bready),
    .s00_axi_araddr  (araddr),
    .s00_axi_arprot  (arprot),
    .s00_axi_arvalid (arvalid),
    .s00_axi_arready (arready),
    .s00_axi_rdata   (rdata),
    .s00_axi_rresp   (rresp),
    .s00_axi_rvalid  (rvalid),
    .s00_axi_rready  (rready),
    .slv_reg0        (slv_reg0),
    .slv_reg1        (slv_reg1),
    .slv_reg2        (slv_reg2),
    .slv_reg3        (slv_reg3)
  );

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_r0"}, slv_reg0, exp_reg[0]);
    check({tag, "_r1"}, slv_reg1, exp_reg[1]);
    check({tag, "_r2"}, slv_reg2, exp_reg[2]);
    check({tag, "_r3"}, slv_reg3, exp_reg[3]);
  endtask

  // ---------------- drivers (enter and leave at posedge+1) ----------------
  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int bp, output logic [1:0] resp);
    bit aw_d = 0, w_d = 0, hold_ok = 1;
    int cyc = 0;
    awaddr = addr; awvalid = 1'b1;
    wdata = data; wstrb = strb; wvalid = 1'b1;
    while (!(aw_d && w_d) && cyc < 20) begin
      @(negedge clk);
      if (awvalid && awready) aw_d = 1;
      if (wvalid && wready) w_d = 1;
      @(posedge clk); #1;
      if (aw_d) awvalid = 1'b0;
      if (w_d) wvalid = 1'b0;
      cyc++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check("wr_accept", 32'(aw_d && w_d), 1);
    cyc = 0;
    @(negedge clk);
    while (!bvalid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("bvalid_seen", bvalid, 1);
    resp = bresp;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      if (!(bvalid && bresp == resp)) hold_ok = 0;
    end
    if (bp > 0) check("b_hold", hold_ok, 1);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit ar_d = 0;
    int cyc = 0;
    araddr = addr; arvalid = 1'b1;
    while (!ar_d && cyc < 20) begin
      @(negedge clk);
      if (arready) ar_d = 1;
      @(posedge clk); #1;
      if (ar_d) arvalid = 1'b0;
      cyc++;
    end
    arvalid = 1'b0;
    check("rd_accept", ar_d, 1);
    cyc = 0;
    @(negedge clk);
    while (!rvalid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("rvalid_seen", rvalid, 1);
    data = rdata; resp = rresp;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d, c1, c2;
    logic [1:0]  r;
    bit w_first, w_k1, bv_early;

    areset = 1'b1;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    foreach (exp_reg[i]) exp_reg[i] = 32'd0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", awready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check_regs("rst");
    areset = 1'b0;
    @(negedge clk);
    check("rdy_after_rst", {awready, wready, arready}, 3'b000);
    @(posedge clk); #1;
    check("rdy_enabled", {awready, wready, arready}, 3'b111);

    // sequential write then readback
    for (int i = 0; i < 4; i++) begin
      axi_write(5'(i * 4), 32'(i + 1), 4'hF, 0, r);
      check("seq_bresp", r, 2'b00);
      exp_reg[i] = 32'(i + 1);
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(5'(i * 4), d, r);
      check("seq_rdata", d, 32'(i + 1));
      check("seq_rresp", r, 2'b00);
    end
    check_regs("seq");

    // W leads AW by three cycles
    wdata = 32'hA5A5A5A5; wstrb = 4'hF; wvalid = 1'b1;
    w_first = 0; w_k1 = 1; bv_early = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) w_first = wready;
      if (k == 1) w_k1 = wready;
      if (bvalid) bv_early = 1;
      @(posedge clk); #1;
      wvalid = 1'b0;
    end
    check("ord_wready", w_first, 1);
    check("ord_wready_low", w_k1, 0);
    check("ord_no_early_b", bv_early, 0);
    awaddr = 5'h08; awvalid = 1'b1;
    @(negedge clk);
    check("ord_awready", awready, 1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    @(negedge clk);
    check("ord_bvalid", bvalid, 1);
    check("ord_bresp", bresp, 2'b00);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    @(negedge clk);
    check("ord_single_b", bvalid, 0);
    @(posedge clk); #1;
    exp_reg[2] = 32'hA5A5A5A5;
    axi_read(5'h08, d, r);
    check("ord_rdata", d, 32'hA5A5A5A5);

    // byte strobes with B backpressure
    axi_write(5'h04, 32'h11223344, 4'hF, 0, r);
    axi_write(5'h04, 32'hFFFFFFFF, 4'h5, 4, r);
    check("strb_bresp", r, 2'b00);
    exp_reg[1] = 32'h11FF33FF;
    axi_read(5'h04, d, r);
    check("strb_rdata", d, 32'h11FF33FF);
    check("strb_slv_reg1", slv_reg1, 32'h11FF33FF);
    axi_write(5'h04, 32'h00000000, 4'h0, 0, r);
    check("strb0_bresp", r, 2'b00);
    check("strb0_slv_reg1", slv_reg1, 32'h11FF33FF);

    // unmapped addresses
    axi_write(5'h1C, 32'hDEADBEEF, 4'hF, 0, r);
    check("unm_1c_bresp", r, 2'b10);
    check_regs("unm_1c");
    axi_read(5'h1C, d, r);
    check("unm_1c_rdata", d, 0);
    check("unm_1c_rresp", r, 2'b10);
    axi_write(5'h10, 32'hCAFEF00D, 4'hF, 0, r);
    check("w10_bresp", r, 2'b10);
    check_regs("w10");
`ifndef CYCLE_NUM_CNT_EN
    axi_read(5'h10, d, r);
    check("unm_10_rdata", d, 0);
    check("unm_10_rresp", r, 2'b10);
`endif

    // read and write to the same register on the same edge
    awaddr = 5'h0C; wdata = 32'h00000055; wstrb = 4'hF; araddr = 5'h0C;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    @(negedge clk);
    check("conc_ready", {awready, wready, arready}, 3'b111);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    check("conc_rvalid", rvalid, 1);
    check("conc_rdata_old", rdata, 32'h4);
    check("conc_bvalid", bvalid, 1);
    bready = 1'b1; rready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0; rready = 1'b0;
    exp_reg[3] = 32'h55;
    check("conc_slv_reg3", slv_reg3, 32'h55);

`ifdef CYCLE_NUM_CNT_EN
    axi_write(5'h00, 32'h2, 4'hF, 0, r);
    axi_write(5'h00, 32'h1, 4'hF, 0, r);
    repeat (100) @(posedge clk);
    #1;
    axi_read(5'h10, c1, r);
    check("cnt_rresp", r, 2'b00);
    check("cnt_range", 32'(c1 >= 100 && c1 <= 110), 1);
    axi_read(5'h10, c2, r);
    check("cnt_increasing", 32'(c2 > c1), 1);
    axi_write(5'h00, 32'h3, 4'hF, 0, r);
    axi_read(5'h00, d, r);
    check("cnt_reg0_selfclr", d, 32'h1);
    axi_read(5'h10, c2, r);
    check("cnt_restart", 32'(c2 < 20), 1);
`endif

    // reset while a B response is pending
    awaddr = 5'h04; wdata = 32'h99; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    check("mid_bvalid_pre", bvalid, 1);
    areset = 1'b1;
    @(posedge clk); #1;
    areset = 1'b0;
    foreach (exp_reg[i]) exp_reg[i] = 32'd0;
    check("mid_bvalid_rst", bvalid, 0);
    check_regs("mid_rst");
    @(posedge clk); #1;
    axi_write(5'h04, 32'h12345678, 4'hF, 0, r);
    check("post_bresp", r, 2'b00);
    axi_read(5'h04, d, r);
    check("post_rdata", d, 32'h12345678);
    check("post_rresp", r, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
